// File: rtl/pipeline_step_ctrl.sv
// pipeline_step_ctrl: owns the global pipeline stall for the MIPS core.
// Host commands free-run, single/multi-step or stop the pipeline; a
// decoded HALT lets the pipeline drain, then freezes it for good.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   i_cmd_valid/i_cmd command handshake (00 CLEAR, 01 RUN, 10 STEP, 11 STOP)
//   i_step_n          STEP cycle count (0 treated as 1)
//   o_cmd_ready       command accepted when valid & ready
//   i_halt_detect     ID-stage instruction is HALT
//   o_stall           registered pipeline stall (1 = frozen)
//   o_done            one-cycle pulse on return to IDLE
//   o_halted          sticky: program reached HALT
//   o_cycle_count     un-stalled cycle count, wraps
//   o_state           00 IDLE, 01 RUN, 10 STEP, 11 DRAIN
module pipeline_step_ctrl #(
    parameter int STEP_W       = 8,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    input  logic [STEP_W-1:0] i_step_n,
    output logic              o_cmd_ready,
    input  logic              i_halt_detect,
    output logic              o_stall,
    output logic              o_done,
    output logic              o_halted,
    output logic [CNT_W-1:0]  o_cycle_count,
    output logic [1:0]        o_state
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_STEP  = 2'b10;
    localparam logic [1:0] S_DRAIN = 2'b11;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_nxt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_nxt;
    logic              done_nxt;
    logic              halted_nxt;

    logic cmd_acc;
    logic is_clear;
    logic is_run;
    logic is_step;
    logic is_stop;

    assign o_state     = state;
    assign o_cmd_ready = (state == S_IDLE) || (state == S_RUN);

    assign cmd_acc  = i_cmd_valid & o_cmd_ready;
    assign is_clear = cmd_acc && (i_cmd == CMD_CLEAR);
    assign is_run   = cmd_acc && (i_cmd == CMD_RUN);
    assign is_step  = cmd_acc && (i_cmd == CMD_STEP);
    assign is_stop  = cmd_acc && (i_cmd == CMD_STOP);

    always_comb begin
        state_nxt  = state;
        step_nxt   = step_cnt;
        drain_nxt  = drain_cnt;
        done_nxt   = 1'b0;
        halted_nxt = o_halted;
        case (state)
            S_IDLE: begin
                // A halted program can only be restarted by reset.
                if (!o_halted) begin
                    if (is_run) begin
                        state_nxt = S_RUN;
                    end else if (is_step) begin
                        state_nxt = S_STEP;
                        step_nxt  = (i_step_n == '0) ?
                                    STEP_W'(1) : i_step_n;
                    end
                end
            end
            S_RUN: begin
                if (i_halt_detect) begin
                    state_nxt = S_DRAIN;
                    drain_nxt = DRAIN_W'(DRAIN_CYCLES);
                end else if (is_stop) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            S_STEP: begin
                // HALT outranks step exhaustion: the step's own done
                // pulse is dropped in favour of the one after DRAIN.
                if (i_halt_detect) begin
                    state_nxt = S_DRAIN;
                    drain_nxt = DRAIN_W'(DRAIN_CYCLES);
                    step_nxt  = '0;
                end else if (step_cnt <= STEP_W'(1)) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step_cnt - STEP_W'(1);
                end
            end
            default: begin
                if (drain_cnt <= DRAIN_W'(1)) begin
                    state_nxt  = S_IDLE;
                    done_nxt   = 1'b1;
                    halted_nxt = 1'b1;
                    drain_nxt  = '0;
                end else begin
                    drain_nxt = drain_cnt - DRAIN_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            step_cnt  <= '0;
            drain_cnt <= '0;
            o_stall   <= 1'b1;
            o_done    <= 1'b0;
            o_halted  <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_cnt  <= step_nxt;
            drain_cnt <= drain_nxt;
            // Stall is registered alongside the state it belongs to.
            o_stall   <= (state_nxt == S_IDLE);
            o_done    <= done_nxt;
            o_halted  <= halted_nxt;
        end
    end

    // CLEAR beats a same-edge increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cycle_count <= '0;
        end else if (is_clear) begin
            o_cycle_count <= '0;
        end else if (!o_stall) begin
            o_cycle_count <= o_cycle_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Randomized scoreboard bench for pipeline_step_ctrl.
// A second instance with a 4-bit counter exercises wrap-around.
module tb_pipeline_step_ctrl;

    localparam int D = 3;
    localparam logic [1:0] C_CLEAR = 2'b00;
    localparam logic [1:0] C_RUN   = 2'b01;
    localparam logic [1:0] C_STEP  = 2'b10;
    localparam logic [1:0] C_STOP  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic [1:0]  i_cmd = 2'b00;
    logic [7:0]  i_step_n = 8'd0;
    logic        i_halt_detect = 1'b0;

    logic        o_cmd_ready, o_stall, o_done, o_halted;
    logic [31:0] o_cycle_count;
    logic [1:0]  o_state;

    logic        w_ready, w_stall, w_done, w_halted;
    logic [3:0]  w_count;
    logic [1:0]  w_state;

    pipeline_step_ctrl dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .i_step_n(i_step_n), .o_cmd_ready(o_cmd_ready),
        .i_halt_detect(i_halt_detect), .o_stall(o_stall),
        .o_done(o_done), .o_halted(o_halted),
        .o_cycle_count(o_cycle_count), .o_state(o_state)
    );

    pipeline_step_ctrl #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .i_step_n(i_step_n), .o_cmd_ready(w_ready),
        .i_halt_detect(i_halt_detect), .o_stall(w_stall),
        .o_done(w_done), .o_halted(w_halted),
        .o_cycle_count(w_count), .o_state(w_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [31:0] cnt;
        logic        halted;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_count = 0;
    logic        model_halted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: counts un-stalled cycles and checks each done pulse
    // against the oldest expectation.
    initial begin
        int   run_len;
        logic prev_done;
        exp_t e;
        run_len   = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_len   = 0;
                prev_done = 1'b0;
            end else begin
                if (!o_stall) run_len++;
                if (o_done && prev_done)
                    chk("done_twice", 32'd1, 32'd0);
                if (o_done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("unstalled_len", run_len, e.len);
                        chk("count", o_cycle_count, e.cnt);
                        chk("count_w", {28'd0, w_count},
                            {28'd0, e.cnt[3:0]});
                        chk("halted", {31'd0, o_halted},
                            {31'd0, e.halted});
                        chk("done_state", {30'd0, o_state}, 32'd0);
                        chk("done_stall", {31'd0, o_stall}, 32'd1);
                        chk("done_w", {31'd0, w_done}, 32'd1);
                    end
                    run_len = 0;
                end
                prev_done = o_done;
            end
        end
    end

    task automatic drive(input logic [1:0] c, input logic [7:0] n);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        i_step_n    = n;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("done_timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_stall"}, {31'd0, o_stall}, 32'd1);
        chk({tag, "_ready"}, {31'd0, o_cmd_ready}, 32'd1);
        chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_halted"}, {31'd0, o_halted}, 32'd0);
        chk({tag, "_count"}, o_cycle_count, 32'd0);
        chk({tag, "_state"}, {30'd0, o_state}, 32'd0);
    endtask

    task automatic frozen_check(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            chk("frozen_stall", {31'd0, o_stall}, 32'd1);
            @(negedge clk);
        end
    endtask

    // Reset asserted away from any clock edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 check_reset_vals("rst");
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        model_count  = 0;
        model_halted = 1'b0;
    endtask

    task automatic do_step(input int n, input int h);
        int   eff;
        exp_t e;
        eff = (n == 0) ? 1 : n;
        drive(C_STEP, 8'(n));
        if (model_halted) begin
            @(negedge clk);
            i_cmd_valid = 1'b0;
            frozen_check(eff + 2);
            return;
        end
        e.len        = (h > 0) ? h + D : eff;
        model_count  = model_count + 32'(e.len);
        model_halted = model_halted | (h > 0);
        e.cnt        = model_count;
        e.halted     = model_halted;
        sb.push_back(e);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        if (h > 0) begin
            repeat (h - 1) @(negedge clk);
            i_halt_detect = 1'b1;
            @(negedge clk);
            i_halt_detect = 1'b0;
        end
        wait_idle();
    endtask

    task automatic do_run(input int j, input int h, input bit stop_too,
                          input int mid, input logic [1:0] mid_cmd);
        exp_t e;
        drive(C_RUN, 8'd0);
        if (model_halted) begin
            @(negedge clk);
            i_cmd_valid = 1'b0;
            frozen_check(4);
            drive(C_STOP, 8'd0);
            @(negedge clk);
            i_cmd_valid = 1'b0;
            frozen_check(2);
            return;
        end
        if (h == 0) begin
            e.len = j;
            if (mid > 0 && mid_cmd == C_CLEAR)
                model_count = 32'(j - mid);
            else
                model_count = model_count + 32'(j);
        end else begin
            e.len        = h + D;
            model_count  = model_count + 32'(e.len);
            model_halted = 1'b1;
        end
        e.cnt    = model_count;
        e.halted = model_halted;
        sb.push_back(e);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        if (h == 0) begin
            for (int i = 1; i < j; i++) begin
                if (i == mid) drive(mid_cmd, 8'd3);
                @(negedge clk);
                i_cmd_valid = 1'b0;
            end
            drive(C_STOP, 8'd0);
            @(negedge clk);
            i_cmd_valid = 1'b0;
        end else begin
            repeat (h - 1) @(negedge clk);
            i_halt_detect = 1'b1;
            if (stop_too) drive(C_STOP, 8'd0);
            @(negedge clk);
            i_halt_detect = 1'b0;
            i_cmd_valid   = 1'b0;
        end
        wait_idle();
    endtask

    task automatic do_clear();
        drive(C_CLEAR, 8'd0);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        model_count = 0;
        chk("clear_count", o_cycle_count, model_count);
        chk("clear_count_w", {28'd0, w_count}, 32'd0);
    endtask

    task automatic post_halt();
        chk("halted_flag", {31'd0, o_halted}, 32'd1);
        do_run(5, 0, 1'b0, 0, C_RUN);
        do_step(3, 0);
        chk("still_halted", {31'd0, o_halted}, 32'd1);
        pulse_reset();
    endtask

    initial begin
        int n;
        int eff;
        int r;
        repeat (2) @(negedge clk);
        check_reset_vals("init");
        #3 rst = 1'b0;
        @(negedge clk);

        do_step(5, 0);
        do_step(0, 0);
        do_run(10, 0, 1'b0, 4, C_RUN);
        do_run(11, 0, 1'b0, 0, C_RUN);
        do_run(8, 0, 1'b0, 3, C_CLEAR);
        do_run(6, 0, 1'b0, 2, C_STEP);

        // Drive the 4-bit counter to all-ones, then CLEAR.
        n = 32'((4'd15 - model_count[3:0]));
        if (n == 0) n = 16;
        do_step(n, 0);
        do_clear();
        do_step(15, 0);
        do_step(1, 0);

        do_run(4, 2, 1'b0, 0, C_RUN);
        post_halt();
        do_step(4, 4);
        post_halt();
        do_run(6, 3, 1'b1, 0, C_RUN);
        post_halt();

        // Reset in the middle of a long STEP.
        drive(C_STEP, 8'd30);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        pulse_reset();

        // Reset in the middle of DRAIN.
        drive(C_RUN, 8'd0);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        @(negedge clk);
        i_halt_detect = 1'b1;
        @(negedge clk);
        i_halt_detect = 1'b0;
        pulse_reset();

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                do_step($urandom_range(0, 12), 0);
            end else if (r <= 6) begin
                n = $urandom_range(2, 15);
                do_run(n, 0, 1'b0, $urandom_range(0, n - 1),
                       2'($urandom_range(0, 2)));
            end else if (r == 7) begin
                n   = $urandom_range(0, 10);
                eff = (n == 0) ? 1 : n;
                do_step(n, $urandom_range(1, eff));
                post_halt();
            end else if (r == 8) begin
                do_run(20, $urandom_range(1, 10),
                       1'($urandom_range(0, 1)), 0, C_RUN);
                post_halt();
            end else begin
                do_clear();
            end
        end

        repeat (3) @(negedge clk);
        chk("final_queue_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_step_ctrl.md
# pipeline_step_ctrl

Execution controller for the MIPS pipeline. It owns the global pipeline stall and drives the `i_stall` input of the `mips` top level. Under a command handshake from the debug/host side it can free-run the pipeline, advance it by an exact number of cycles, or stop it. When a HALT instruction is decoded it lets the pipeline drain, then freezes it and counts executed cycles.

## Interface
- `STEP_W`, 8: width of the step-count field.
- `CNT_W`, 32: width of the executed-cycle counter.
- `DRAIN_CYCLES`, 3: cycles the pipeline keeps running after HALT is decoded in ID, so that older instructions retire. Must be ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_cmd_valid`  in  1  command present.
- `i_cmd`  in  2  command code: 00 CLEAR (zero the counter), 01 RUN, 10 STEP, 11 STOP.
- `i_step_n`  in  STEP_W  cycle count for STEP. The value 0 is treated as 1.
- `o_cmd_ready`  out  1  the command is accepted on an edge where `i_cmd_valid & o_cmd_ready`.
- `i_halt_detect`  in  1  the ID-stage instruction is HALT (combinational from decode).
- `o_stall`  out  1  registered; drives pipeline `i_stall`. 1 = frozen.
- `o_done`  out  1  one-cycle pulse marking the return to IDLE.
- `o_halted`  out  1  sticky flag: the program reached HALT.
- `o_cycle_count`  out  CNT_W  number of un-stalled cycles, wraps modulo 2^CNT_W.
- `o_state`  out  2  00 IDLE, 01 RUN, 10 STEP, 11 DRAIN.

## Operation
- Reset values: state IDLE, `o_stall`=1, `o_cmd_ready`=1, `o_done`=0, `o_halted`=0, `o_cycle_count`=0, step and drain counters 0.
- **IDLE**: `o_stall`=1, `o_cmd_ready`=1.
  - CLEAR zeroes `o_cycle_count`.
  - RUN goes to RUN.
  - STEP loads `max(i_step_n,1)` into the step counter and goes to STEP.
  - STOP has no effect.
  - If `o_halted`=1, RUN and STEP are consumed with no effect. Only `rst` clears `o_halted`.
- **RUN**: `o_stall`=0, `o_cmd_ready`=1.
  - STOP goes to IDLE and pulses `o_done`.
  - CLEAR zeroes the counter. RUN and STEP are consumed and ignored.
- **STEP**: `o_stall`=0, `o_cmd_ready`=0. The step counter decrements each cycle. When it reaches its last cycle (counter==1), the next state is IDLE with an `o_done` pulse.
- **DRAIN**: `o_stall`=0, `o_cmd_ready`=0. The drain counter is loaded with DRAIN_CYCLES on entry and decrements each cycle. After the last drain cycle the block goes to IDLE, pulses `o_done` and sets `o_halted`.
- HALT detection is sampled only while `o_stall`=0 (RUN or STEP). When `i_halt_detect` is seen, the next state is DRAIN.
- Priority, highest first: HALT detection, then STOP command, then step-count exhaustion.
- `o_cycle_count` increments on every edge where `o_stall`=0 (registered value), DRAIN included.
- If CLEAR is accepted on the same edge as an increment, CLEAR wins and the result is 0.

## Timing
- A command accepted at edge T changes state at T. `o_stall` falls in the cycle after T, because it is registered together with the state.
- STEP with N≥1: `o_stall` is low for exactly N cycles and high again on the following edge. `o_done` is high in that first re-stalled cycle.
- STOP accepted in RUN at edge T: `o_stall`=1 and `o_done`=1 in the cycle after T. No further counting.
- HALT detected on the edge ending un-stalled cycle k: cycles k+1 through k+DRAIN_CYCLES are un-stalled. `o_stall`, `o_done` and `o_halted` rise together at the next edge.
- HALT detected during the last STEP cycle: DRAIN is entered. There is no `o_done` for the STEP itself, only the single `o_done` at the end of DRAIN.
- `rst` asserted mid-operation: all outputs return immediately (asynchronously) to their reset values, and any in-flight STEP or DRAIN is discarded.
- `o_done` is never high for two consecutive cycles.

## Test plan
- Reset, then STEP with N=5 → `o_stall` low for exactly 5 cycles, `o_done` pulses once, `o_cycle_count`=5, state IDLE.
- STEP with `i_step_n`=0 → exactly 1 un-stalled cycle, `o_cycle_count` increments by 1.
- RUN, 10 cycles later STOP → 10 or 11 un-stalled cycles (matching the acceptance edge), then `o_done`. A RUN command issued during RUN is ignored.
- RUN with `i_halt_detect` pulsed once → DRAIN_CYCLES (3) further un-stalled cycles, then `o_halted`=1 and `o_done`. A subsequent RUN is accepted but `o_stall` stays 1.
- STEP N=4 with HALT on its 4th cycle → DRAIN is entered, 3 more un-stalled cycles, a single `o_done`, `o_cycle_count`=7. STOP in the same cycle as HALT → DRAIN wins.
- `rst` asserted mid-STEP and mid-DRAIN → immediate `o_stall`=1 and count 0. CLEAR on a counter at 2^CNT_W−1 gives 0. Without CLEAR, the counter wraps to 0 on the next un-stalled cycle.
